step_counter: RTL and testbench
===============================

# step_counter

Parametrised up/down counter with configurable width, terminal value, per-cycle step size, wrap or saturate mode, parallel load and sticky overflow/underflow flags. It is the general-purpose successor to the fixed 4-bit overflow counter and serves as the event, timeout and index counter across the design. All outputs are registered except the `at_max`/`at_zero` decodes. Overflow is flagged on the same edge that the count wraps or saturates.

## Interface
- `WIDTH`, 8: counter width in bits (≥2).
- `MAX_VAL`, 2^WIDTH−1: terminal value; legal count range is 0..MAX_VAL (must be ≤ 2^WIDTH−1).
- `SATURATE`, 0: 0 = wrap modulo MAX_VAL+1; 1 = clamp at 0 / MAX_VAL.

Ports:
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `enable` input 1: perform one step this cycle.
- `up` input 1: direction; 1 = increment, 0 = decrement.
- `step` input WIDTH: step magnitude; values > MAX_VAL are treated as MAX_VAL.
- `load` input 1: load `load_value` this cycle.
- `load_value` input WIDTH: value to load; values > MAX_VAL are loaded as MAX_VAL.
- `flag_clear` input 1: clear sticky flags.
- `counter_out` output WIDTH: current count (registered).
- `overflow_out` output 1: sticky, set on any up-direction range event.
- `underflow_out` output 1: sticky, set on any down-direction range event.
- `event_pulse` output 1: high for exactly one cycle after any range event.
- `at_max` output 1: combinational, `counter_out == MAX_VAL`.
- `at_zero` output 1: combinational, `counter_out == 0`.

## Operation
- Priority per edge: `reset` > `load` > `enable`. With none asserted, the count holds.
- Reset: `counter_out`=0, `overflow_out`=0, `underflow_out`=0, `event_pulse`=0. This applies regardless of `load`/`enable`/`flag_clear`.
- Load: `counter_out` ← min(`load_value`, MAX_VAL). Flags are unchanged, no event is generated, and `enable` is ignored that cycle.
- Arithmetic is done at WIDTH+1 bits; let s = min(`step`, MAX_VAL).
- Up, count+s ≤ MAX_VAL: count ← count+s.
- Up, count+s > MAX_VAL (overflow event):
  - Wrap mode: count ← count+s−(MAX_VAL+1).
  - Saturate mode: count ← MAX_VAL.
- Down, s ≤ count: count ← count−s.
- Down, s > count (underflow event):
  - Wrap mode: count ← count+(MAX_VAL+1)−s.
  - Saturate mode: count ← 0.
- `step`=0 with `enable`: count unchanged, no event.
- In saturate mode, every enabled step that would exceed the range is an event, including when already at the limit.
- Sticky flags: set by their event and held until `reset` or `flag_clear`. If `flag_clear` and an event occur on the same edge, the event wins and the flag is 1. `flag_clear` clears both flags.
- `event_pulse` ← 1 on the edge an event occurs and 0 otherwise. It is never held by a subsequent idle cycle.

## Timing
- Latency is 1 cycle for every registered action: the input is sampled at edge N and the result is visible after edge N.
- Count update, flag set and `event_pulse` all occur on the same edge as the wrap/saturation. There is no trailing-cycle flag.
- `at_max`/`at_zero` follow `counter_out` combinationally, with no extra latency.
- There is no handshake; `enable` may be held for back-to-back steps, one per cycle.
- Reset asserted mid-count takes effect on the next edge; counting resumes on the first edge after `reset` deasserts.

## Test plan
- WIDTH=4, MAX_VAL=13, SATURATE=0, up, `step`=2 from 0 → 0,2,4,…,12, then 0. `overflow_out`=1 and `event_pulse`=1 for one cycle on the 12→0 edge.
- Same config, down, `step`=3 from 1 → 12 with `underflow_out`=1 and `overflow_out` unchanged. Then `step`=0 with `enable` → count 12 holds, `event_pulse`=0.
- SATURATE=1, MAX_VAL=13, up, `step`=5 from 10 → 13 with `overflow_out`=1 and `event_pulse`=1. The next enabled cycle stays at 13 with `event_pulse`=1 again, and `at_max`=1.
- `load_value`=15 with MAX_VAL=13 → 13. `load`+`enable` in the same cycle (load 4, up, step 2) → 4, not 6.
- Flags set, `flag_clear` alone → both flags 0 next cycle. `flag_clear` on the same edge as an overflow event → `overflow_out`=1.
- Count 9 with both flags set, `reset` asserted together with `load` and `enable` → `counter_out`=0, all flags 0, `event_pulse`=0, `at_zero`=1.

Source files
------------

// File: rtl/step_counter.sv
// Parametrised up/down counter with a configurable terminal value, per-cycle step,
// wrap or saturate behaviour, parallel load and sticky overflow/underflow flags.
module step_counter #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             flag_clear,
  output logic [WIDTH-1:0] counter_out,
  output logic             overflow_out,
  output logic             underflow_out,
  output logic             event_pulse,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH:0] MAX_EXT = {1'b0, MAX_VAL};
  localparam logic [WIDTH:0] MODULUS = MAX_EXT + {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] step_clamped;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   up_wrapped;
  logic [WIDTH:0]   down_diff;
  logic [WIDTH:0]   down_wrapped;
  logic             up_event;
  logic             down_event;
  logic [WIDTH-1:0] next_count;
  logic             step_event;

  // All range arithmetic is one bit wider than the count so sums never alias.
  always_comb begin
    step_clamped = (step > MAX_VAL) ? MAX_VAL : step;
    load_clamped = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    count_ext    = {1'b0, counter_out};
    step_ext     = {1'b0, step_clamped};
    up_sum       = count_ext + step_ext;
    up_wrapped   = up_sum - MODULUS;
    down_diff    = count_ext - step_ext;
    down_wrapped = count_ext + MODULUS - step_ext;
    up_event     = up_sum > MAX_EXT;
    down_event   = step_ext > count_ext;
    next_count   = counter_out;
    step_event   = 1'b0;
    if (up) begin
      step_event = up_event;
      if (!up_event)
        next_count = up_sum[WIDTH-1:0];
      else if (SATURATE)
        next_count = MAX_VAL;
      else
        next_count = up_wrapped[WIDTH-1:0];
    end else begin
      step_event = down_event;
      if (!down_event)
        next_count = down_diff[WIDTH-1:0];
      else if (SATURATE)
        next_count = '0;
      else
        next_count = down_wrapped[WIDTH-1:0];
    end
  end

  logic do_step;
  logic overflow_set;
  logic underflow_set;

  always_comb begin
    do_step       = enable && !load;
    overflow_set  = do_step && up && step_event;
    underflow_set = do_step && !up && step_event;
  end

  // A flag set on the same edge as flag_clear survives: the event has priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_out   <= '0;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
      event_pulse   <= 1'b0;
    end else begin
      if (load)
        counter_out <= load_clamped;
      else if (enable)
        counter_out <= next_count;
      overflow_out  <= overflow_set || (overflow_out && !flag_clear);
      underflow_out <= underflow_set || (underflow_out && !flag_clear);
      event_pulse   <= overflow_set || underflow_set;
    end
  end

  assign at_max  = (counter_out == MAX_VAL);
  assign at_zero = (counter_out == '0);

endmodule

// File: tb/tb_step_counter.sv
// Bench for step_counter: a wrap-mode and a saturate-mode instance (WIDTH=4, MAX_VAL=13)
// driven from a vector table; expected results travel through a scoreboard queue.
module tb_step_counter;

  typedef struct {
    int         dut;
    logic       rst;
    logic       ld;
    logic       en;
    logic       up;
    logic       clr;
    logic [3:0] step;
    logic [3:0] ldv;
    logic [3:0] cnt;
    logic       ovf;
    logic       unf;
    logic       evt;
    logic       amax;
    logic       azero;
    string      name;
  } vec_t;

  logic       clk;
  logic       reset_i      [2];
  logic       enable_i     [2];
  logic       up_i         [2];
  logic [3:0] step_i       [2];
  logic       load_i       [2];
  logic [3:0] load_value_i [2];
  logic       flag_clear_i [2];
  logic [3:0] count_o      [2];
  logic       overflow_o   [2];
  logic       underflow_o  [2];
  logic       event_o      [2];
  logic       at_max_o     [2];
  logic       at_zero_o    [2];

  vec_t vectors[$];
  vec_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  step_counter #(.WIDTH(4), .MAX_VAL(4'd13), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset_i[0]), .enable(enable_i[0]), .up(up_i[0]),
    .step(step_i[0]), .load(load_i[0]), .load_value(load_value_i[0]),
    .flag_clear(flag_clear_i[0]), .counter_out(count_o[0]),
    .overflow_out(overflow_o[0]), .underflow_out(underflow_o[0]),
    .event_pulse(event_o[0]), .at_max(at_max_o[0]), .at_zero(at_zero_o[0])
  );

  step_counter #(.WIDTH(4), .MAX_VAL(4'd13), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset_i[1]), .enable(enable_i[1]), .up(up_i[1]),
    .step(step_i[1]), .load(load_i[1]), .load_value(load_value_i[1]),
    .flag_clear(flag_clear_i[1]), .counter_out(count_o[1]),
    .overflow_out(overflow_o[1]), .underflow_out(underflow_o[1]),
    .event_pulse(event_o[1]), .at_max(at_max_o[1]), .at_zero(at_zero_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int dut, logic rst, logic ld, logic en, logic up,
                              logic clr, logic [3:0] step, logic [3:0] ldv,
                              logic [3:0] cnt, logic ovf, logic unf, logic evt,
                              logic amax, logic azero, string name);
    vec_t v;
    v.dut = dut; v.rst = rst; v.ld = ld; v.en = en; v.up = up; v.clr = clr;
    v.step = step; v.ldv = ldv; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    v.evt = evt; v.amax = amax; v.azero = azero; v.name = name;
    return v;
  endfunction

  task automatic compare(input string name, input string field,
                         input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s.%s: got %0d expected %0d", name, field, act, exp);
    end
  endtask

  task automatic idleInputs();
    for (int d = 0; d < 2; d++) begin
      reset_i[d] = 1'b0; enable_i[d] = 1'b0; up_i[d] = 1'b0; step_i[d] = '0;
      load_i[d] = 1'b0; load_value_i[d] = '0; flag_clear_i[d] = 1'b0;
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = exp_q.pop_front();
    compare(e.name, "count",     count_o[e.dut],            e.cnt);
    compare(e.name, "overflow",  {3'b0, overflow_o[e.dut]},  {3'b0, e.ovf});
    compare(e.name, "underflow", {3'b0, underflow_o[e.dut]}, {3'b0, e.unf});
    compare(e.name, "event",     {3'b0, event_o[e.dut]},     {3'b0, e.evt});
    compare(e.name, "at_max",    {3'b0, at_max_o[e.dut]},    {3'b0, e.amax});
    compare(e.name, "at_zero",   {3'b0, at_zero_o[e.dut]},   {3'b0, e.azero});
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    idleInputs();
    reset_i[v.dut]      = v.rst;
    load_i[v.dut]       = v.ld;
    enable_i[v.dut]     = v.en;
    up_i[v.dut]         = v.up;
    flag_clear_i[v.dut] = v.clr;
    step_i[v.dut]       = v.step;
    load_value_i[v.dut] = v.ldv;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    idleInputs();
    //               dut rst ld en up clr stp ldv  cnt ovf unf evt max zero
    vectors.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, "w_reset"));
    for (int i = 1; i <= 6; i++)
      vectors.push_back(mk(0, 0, 0, 1, 1, 0, 2, 0, 4'(2 * i), 0, 0, 0, 0, 0, "w_up2"));
    vectors.push_back(mk(0, 0, 0, 1, 1, 0, 2, 0,  0, 1, 0, 1, 0, 1, "w_wrap_12_to_0"));
    vectors.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, "w_idle_pulse_drops"));
    vectors.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0, 0, "w_load1"));
    vectors.push_back(mk(0, 0, 0, 1, 0, 0, 3, 0, 12, 1, 1, 1, 0, 0, "w_down3_underflow"));
    vectors.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 12, 1, 1, 0, 0, 0, "w_step0_hold"));
    vectors.push_back(mk(0, 0, 0, 1, 1, 0, 15, 0, 11, 1, 1, 1, 0, 0, "w_step_clamped"));
    vectors.push_back(mk(0, 0, 1, 0, 0, 0, 0, 15, 13, 1, 1, 0, 1, 0, "w_load15_clamp"));
    vectors.push_back(mk(0, 0, 1, 1, 1, 0, 2, 4,  4, 1, 1, 0, 0, 0, "w_load_beats_enable"));
    vectors.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0,  4, 0, 0, 0, 0, 0, "w_flag_clear"));
    vectors.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, "s_reset"));
    vectors.push_back(mk(1, 0, 1, 0, 0, 0, 0, 10, 10, 0, 0, 0, 0, 0, "s_load10"));
    vectors.push_back(mk(1, 0, 0, 1, 1, 0, 5, 0, 13, 1, 0, 1, 1, 0, "s_sat_up"));
    vectors.push_back(mk(1, 0, 0, 1, 1, 0, 5, 0, 13, 1, 0, 1, 1, 0, "s_sat_again"));
    vectors.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 13, 1, 0, 0, 1, 0, "s_idle"));
    vectors.push_back(mk(1, 0, 0, 1, 0, 0, 13, 0, 0, 1, 0, 0, 0, 1, "s_down_exact_zero"));
    vectors.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0,  0, 1, 1, 1, 0, 1, "s_sat_down"));
    vectors.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1, "s_flag_clear"));
    vectors.push_back(mk(1, 0, 1, 0, 0, 0, 0, 9,  9, 0, 0, 0, 0, 0, "s_load9"));
    vectors.push_back(mk(1, 0, 0, 1, 1, 1, 5, 0, 13, 1, 0, 1, 1, 0, "s_clear_vs_event"));
    vectors.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, "s_load0"));
    vectors.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0,  0, 1, 1, 1, 0, 1, "s_underflow2"));
    vectors.push_back(mk(1, 0, 1, 0, 0, 0, 0, 9,  9, 1, 1, 0, 0, 0, "s_load9_flags"));
    vectors.push_back(mk(1, 1, 1, 1, 1, 1, 1, 5,  0, 0, 0, 0, 0, 1, "s_reset_wins"));
    vectors.push_back(mk(1, 0, 0, 1, 1, 0, 1, 0,  1, 0, 0, 0, 0, 0, "s_resume"));

    foreach (vectors[i]) applyStimulus(vectors[i]);

    // Back-to-back wrap steps, then a reset in the middle of counting.
    applyStimulus(mk(0, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, "h_load0"));
    applyStimulus(mk(0, 0, 0, 1, 1, 0, 5, 0,  5, 0, 0, 0, 0, 0, "h_up5_a"));
    applyStimulus(mk(0, 0, 0, 1, 1, 0, 5, 0, 10, 0, 0, 0, 0, 0, "h_up5_b"));
    applyStimulus(mk(0, 0, 0, 1, 1, 0, 5, 0,  1, 1, 0, 1, 0, 0, "h_up5_wrap"));
    applyStimulus(mk(0, 0, 0, 1, 1, 0, 5, 0,  6, 1, 0, 0, 0, 0, "h_up5_after"));
    applyStimulus(mk(0, 1, 0, 1, 1, 0, 5, 0,  0, 0, 0, 0, 0, 1, "h_mid_reset"));
    applyStimulus(mk(0, 0, 0, 1, 1, 0, 5, 0,  5, 0, 0, 0, 0, 0, "h_after_reset"));

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
